// File: rtl/emif_access_ctrl.sv
// rtl/emif_access_ctrl.sv - EMIF strobe synchroniser and access sequencer for the FPGA register file
// Decodes MCU EMIF strobes into qualified register-file write/read transactions with sticky error flags.
module emif_access_ctrl #(
  parameter int SETTLE_CYC  = 5,
  parameter int ADDR_DEPTH  = 8,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        emif_cs_n,
  input  logic        emif_we_n,
  input  logic        emif_oe_n,
  input  logic [12:0] emif_addr,
  input  logic [15:0] emif_data_in,
  input  logic [15:0] rd_data,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_req,
  output logic [12:0] rd_addr,
  output logic [15:0] emif_data_out,
  output logic        emif_data_oe,
  output logic        busy,
  output logic        timeout_err,
  output logic        addr_err,
  output logic        proto_err
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int              CNT_W    = 8;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] RDLAT_L  = CNT_W'(RD_LAT - 1);
  localparam logic [12:0]      DEPTH_L  = 13'(ADDR_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETTLE, S_WR_COMMIT, S_RD_REQ, S_RD_WAIT, S_RD_DRIVE, S_RELEASE
  } state_e;

  logic [1:0]       cs_sync_q, we_sync_q, oe_sync_q;
  logic             cs_s, we_s, oe_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [12:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [15:0]      wr_data_q, wr_data_d, dout_q, dout_d;
  logic             timeout_err_q, timeout_err_d;
  logic             addr_err_q, addr_err_d;
  logic             proto_err_q, proto_err_d;
  logic             set_tmo, set_addr, set_proto, tmo_fire;
  logic             wr_addr_ok, rd_addr_ok;

  // Strobes idle high, so the synchronisers reset to the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q <= 2'b11;
      we_sync_q <= 2'b11;
      oe_sync_q <= 2'b11;
    end else begin
      cs_sync_q <= {cs_sync_q[0], emif_cs_n};
      we_sync_q <= {we_sync_q[0], emif_we_n};
      oe_sync_q <= {oe_sync_q[0], emif_oe_n};
    end
  end

  assign cs_s       = cs_sync_q[1];
  assign we_s       = we_sync_q[1];
  assign oe_s       = oe_sync_q[1];
  assign wr_addr_ok = (wr_addr_q < DEPTH_L);
  assign rd_addr_ok = (rd_addr_q < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      dout_q        <= '0;
      timeout_err_q <= 1'b0;
      addr_err_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_addr_q     <= rd_addr_d;
      dout_q        <= dout_d;
      timeout_err_q <= timeout_err_d;
      addr_err_q    <= addr_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    dout_d    = dout_q;
    set_tmo   = 1'b0;
    set_addr  = 1'b0;
    set_proto = 1'b0;
    tmo_fire  = 1'b0;

    // Saturating watchdog; fires once, on the step that reaches TIMEOUT_CYC.
    if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d    = tmo_q + TMO_W'(1);
      tmo_fire = (tmo_q + TMO_W'(1) == TMO_MAX);
    end

    case (state_q)
      S_IDLE: begin
        if (!cs_s && !we_s && !oe_s) begin
          set_proto = 1'b1;
          state_d   = S_RELEASE;
        end else if (!cs_s && !we_s) begin
          cnt_d   = '0;
          state_d = S_WR_SETTLE;
        end else if (!cs_s && !oe_s) begin
          rd_addr_d = emif_addr;
          state_d   = S_RD_REQ;
        end
      end
      S_WR_SETTLE: begin
        if (cs_s || we_s) begin
          state_d = S_IDLE;
        end else if (cnt_q + CNT_W'(1) == SETTLE_L) begin
          wr_addr_d = emif_addr;
          wr_data_d = emif_data_in;
          state_d   = S_WR_COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_COMMIT: begin
        set_addr = !wr_addr_ok;
        state_d  = S_RELEASE;
      end
      S_RD_REQ: begin
        set_addr = !rd_addr_ok;
        cnt_d    = '0;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == RDLAT_L) begin
          dout_d  = rd_addr_ok ? rd_data : 16'h0000;
          state_d = S_RD_DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_DRIVE: begin
        if (oe_s || cs_s) state_d = S_IDLE;
      end
      S_RELEASE: begin
        if (cs_s || (we_s && oe_s)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_fire) begin
      set_tmo = 1'b1;
      state_d = S_RELEASE;
    end

    // A new error in the same cycle as err_clr wins.
    timeout_err_d = (timeout_err_q && !err_clr) || set_tmo;
    addr_err_d    = (addr_err_q    && !err_clr) || set_addr;
    proto_err_d   = (proto_err_q   && !err_clr) || set_proto;
  end

  assign wr_en         = (state_q == S_WR_COMMIT) && wr_addr_ok;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_req        = (state_q == S_RD_REQ) && rd_addr_ok;
  assign rd_addr       = rd_addr_q;
  assign emif_data_out = dout_q;
  assign emif_data_oe  = (state_q == S_RD_DRIVE);
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = timeout_err_q;
  assign addr_err      = addr_err_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_emif_access_ctrl.sv
// tb/tb_emif_access_ctrl.sv - randomized self-checking bench for emif_access_ctrl against a transaction-level model
`timescale 1ns/100ps
module tb_emif_access_ctrl;
  localparam int SETTLE_CYC  = 5;
  localparam int ADDR_DEPTH  = 8;
  localparam int RD_LAT      = 1;
  localparam int TIMEOUT_CYC = 255;
  // Strobe driven before edge 0 is seen synchronised in cycle 1 and decoded into cycle 2.
  localparam int T_BUSY      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        emif_cs_n, emif_we_n, emif_oe_n;
  logic [12:0] emif_addr;
  logic [15:0] emif_data_in, rd_data;
  logic        err_clr;
  logic        wr_en, rd_req, emif_data_oe, busy, timeout_err, addr_err, proto_err;
  logic [12:0] wr_addr, rd_addr;
  logic [15:0] wr_data, emif_data_out;

  always #2.5 clk = ~clk;

  emif_access_ctrl #(
    .SETTLE_CYC(SETTLE_CYC), .ADDR_DEPTH(ADDR_DEPTH), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .emif_cs_n(emif_cs_n), .emif_we_n(emif_we_n), .emif_oe_n(emif_oe_n),
    .emif_addr(emif_addr), .emif_data_in(emif_data_in), .rd_data(rd_data), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .emif_data_out(emif_data_out), .emif_data_oe(emif_data_oe), .busy(busy),
    .timeout_err(timeout_err), .addr_err(addr_err), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem [ADDR_DEPTH];
  bit          m_tmo, m_addr, m_proto;

  int          o_wr_cnt, o_wr_cyc, o_rd_cnt, o_rd_cyc, o_oe_cnt, o_oe_first, o_oe_last;
  int          o_overlap, o_tmo_first, o_busy_first, rd_pend;
  logic [12:0] o_wr_addr, o_rd_addr;
  logic [15:0] o_wr_data, o_dout;

  task automatic clear_obs();
    o_wr_cnt = 0; o_wr_cyc = -1; o_rd_cnt = 0; o_rd_cyc = -1; o_oe_cnt = 0;
    o_oe_first = -1; o_oe_last = -1; o_overlap = 0; o_tmo_first = -1; o_busy_first = -1;
    o_wr_addr = '0; o_wr_data = '0; o_rd_addr = '0; o_dout = '0;
  endtask

  // Called at each negedge: records DUT activity and plays the register file.
  task automatic sample(input int cyc);
    if (wr_en) begin
      o_wr_cnt++;
      if (o_wr_cnt == 1) begin o_wr_cyc = cyc; o_wr_addr = wr_addr; o_wr_data = wr_data; end
    end
    if (wr_en && rd_req) o_overlap++;
    if (busy && o_busy_first < 0) o_busy_first = cyc;
    if (timeout_err && o_tmo_first < 0) o_tmo_first = cyc;
    if (emif_data_oe) begin
      o_oe_cnt++;
      if (o_oe_first < 0) o_oe_first = cyc;
      o_oe_last = cyc;
      o_dout    = emif_data_out;
    end
    if (rd_req) begin
      o_rd_cnt++; o_rd_cyc = cyc; o_rd_addr = rd_addr;
      rd_pend = RD_LAT;
      rd_data = 16'($urandom);
    end else if (rd_pend > 0) begin
      rd_pend--;
      rd_data = (rd_pend == 0 && o_rd_addr < ADDR_DEPTH) ? mem[o_rd_addr[2:0]] : 16'($urandom);
    end else begin
      rd_data = 16'($urandom);
    end
  endtask

  task automatic run_access(input bit do_we, input bit do_oe, input logic [12:0] addr,
                            input logic [15:0] data, input int hold, input int win, input int clr_cyc);
    clear_obs();
    emif_addr = addr; emif_data_in = data;
    emif_cs_n = 1'b0; emif_we_n = !do_we; emif_oe_n = !do_oe;
    for (int c = 0; c < win; c++) begin
      @(negedge clk);
      sample(c);
      err_clr = (c == clr_cyc);
      if (c == hold - 1) begin emif_cs_n = 1'b1; emif_we_n = 1'b1; emif_oe_n = 1'b1; end
    end
    err_clr = 1'b0;
  endtask

  task automatic check_end(input string tag);
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_flags"}, {timeout_err, addr_err, proto_err}, {m_tmo, m_addr, m_proto});
  endtask

  task automatic do_write(input logic [12:0] addr, input logic [15:0] data, input int hold);
    bit committed, good;
    run_access(1'b1, 1'b0, addr, data, hold, hold + 12, -1);
    committed = (hold >= SETTLE_CYC + 1);
    good      = (addr < ADDR_DEPTH);
    check_eq("wr_busy_start", o_busy_first, T_BUSY);
    if (committed && good) begin
      check_eq("wr_cnt", o_wr_cnt, 1);
      check_eq("wr_cyc", o_wr_cyc, SETTLE_CYC + 2);
      check_eq("wr_addr", o_wr_addr, addr);
      check_eq("wr_data", o_wr_data, data);
      mem[addr[2:0]] = data;
    end else begin
      check_eq("wr_none", o_wr_cnt, 0);
    end
    if (committed && !good) m_addr = 1'b1;
    check_eq("wr_no_read", o_rd_cnt + o_oe_cnt + o_overlap, 0);
    check_end("wr");
  endtask

  task automatic do_read(input logic [12:0] addr, input int hold);
    bit good;
    int exp_first, exp_last;
    logic [15:0] exp_d;
    good      = (addr < ADDR_DEPTH);
    exp_d     = good ? mem[addr[2:0]] : 16'h0000;
    exp_first = T_BUSY + 1 + RD_LAT;
    exp_last  = (hold + 1 > exp_first) ? hold + 1 : exp_first;
    run_access(1'b0, 1'b1, addr, 16'h0, hold, hold + 10, -1);
    check_eq("rd_busy_start", o_busy_first, T_BUSY);
    check_eq("rd_req_cnt", o_rd_cnt, good ? 1 : 0);
    if (good) begin
      check_eq("rd_req_cyc", o_rd_cyc, T_BUSY);
      check_eq("rd_addr", o_rd_addr, addr);
    end else begin
      m_addr = 1'b1;
    end
    check_eq("rd_oe_first", o_oe_first, exp_first);
    check_eq("rd_oe_last", o_oe_last, exp_last);
    check_eq("rd_oe_cnt", o_oe_cnt, exp_last - exp_first + 1);
    check_eq("rd_data_out", o_dout, exp_d);
    check_eq("rd_data_hold", emif_data_out, exp_d);
    check_eq("rd_no_write", o_wr_cnt + o_overlap, 0);
    check_end("rd");
  endtask

  task automatic do_proto(input int hold, input bit clr_same_cycle);
    run_access(1'b1, 1'b1, 13'($urandom_range(0, 7)), 16'($urandom), hold, hold + 10,
               clr_same_cycle ? 1 : -1);
    if (clr_same_cycle) begin m_tmo = 1'b0; m_addr = 1'b0; end
    m_proto = 1'b1;
    check_eq("pr_busy_start", o_busy_first, T_BUSY);
    check_eq("pr_no_access", o_wr_cnt + o_rd_cnt + o_oe_cnt, 0);
    check_end("pr");
  endtask

  task automatic clear_errors();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_tmo = 1'b0; m_addr = 1'b0; m_proto = 1'b0;
    check_eq("err_clr", {timeout_err, addr_err, proto_err}, 3'b000);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; rd_data = '0; rd_pend = 0;
    emif_cs_n = 1'b1; emif_we_n = 1'b1; emif_oe_n = 1'b1;
    emif_addr = '0; emif_data_in = '0;
    m_tmo = 1'b0; m_addr = 1'b0; m_proto = 1'b0;
    for (int i = 0; i < ADDR_DEPTH; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {wr_en, rd_req, emif_data_oe, busy}, 4'b0000);
    check_eq("rst_flags", {timeout_err, addr_err, proto_err}, 3'b000);
    check_eq("rst_data", {emif_data_out, wr_data}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_write(13'd3, 16'h0012, 20);
    do_write(13'd3, 16'h7777, 3);
    mem[5] = 16'hA5A5;
    do_read(13'd5, 10);
    do_read(13'd3, 8);
    do_write(13'd9, 16'h1234, 10);
    clear_errors();
    do_read(13'd12, 6);
    do_proto(4, 1'b0);
    do_write(13'd10, 16'h4321, 8);
    do_proto(3, 1'b1);
    clear_errors();

    run_access(1'b0, 1'b1, 13'd2, 16'h0, 300, 310, -1);
    m_tmo = 1'b1;
    check_eq("tmo_first", o_tmo_first, T_BUSY + TIMEOUT_CYC);
    check_eq("tmo_oe_last", o_oe_last, T_BUSY + TIMEOUT_CYC - 1);
    check_eq("tmo_oe_first", o_oe_first, T_BUSY + 1 + RD_LAT);
    check_eq("tmo_rd_data", emif_data_out, mem[2]);
    check_end("tmo");
    clear_errors();

    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5)      do_write(13'($urandom_range(0, 11)), 16'($urandom), $urandom_range(1, 14));
      else if (kind < 9) do_read(13'($urandom_range(0, 11)), $urandom_range(2, 20));
      else               do_proto($urandom_range(1, 8), 1'b0);
      if ($urandom_range(0, 3) == 0) clear_errors();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    do_proto(2, 1'b0);
    clear_obs();
    emif_addr = 13'd5; emif_cs_n = 1'b0; emif_oe_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sample(c);
      if (emif_data_oe) break;
    end
    check_eq("rst_pre_oe", emif_data_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", {wr_en, rd_req, emif_data_oe, busy}, 4'b0000);
    check_eq("rst_mid_flags", {timeout_err, addr_err, proto_err}, 3'b000);
    check_eq("rst_mid_data", {emif_data_out, wr_data}, 32'h0);
    check_eq("rst_mid_addr", {wr_addr, rd_addr}, 26'h0);
    emif_cs_n = 1'b1; emif_oe_n = 1'b1; rd_pend = 0;
    m_tmo = 1'b0; m_addr = 1'b0; m_proto = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_read(13'd5, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
